// File: rtl/shuffle_perm_gen.sv
// Fisher-Yates permutation generator: fills an index table, shuffles it with a seeded
// Galois LFSR, then streams it out. Define SHUFFLE_INV_EN to add an inverse-lookup port.
module shuffle_perm_gen #(
    parameter int IDX_W  = 6,
    parameter int LFSR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
`ifdef SHUFFLE_INV_EN
    ,
    input  logic [IDX_W-1:0]  inv_addr,
    output logic [IDX_W-1:0]  inv_idx
`endif
);
    localparam int                N         = 1 << IDX_W;
    localparam logic [IDX_W-1:0]  CNT_MAX   = IDX_W'(N - 1);
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(32'h8020_0003);

    typedef enum logic [1:0] {IDLE, INIT, SHUF, STREAM} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   cnt_reg, cnt_inc;
    logic [LFSR_W-1:0]  lfsr_reg, lfsr_next;
    logic [IDX_W-1:0]   perm_tab [N];
    logic [2*IDX_W-1:0] i_plus;
    logic [IDX_W-1:0]   swap_j, val_i, val_j;
    logic               accept;

    assign accept    = out_valid && out_ready;
    assign busy      = (state_reg != IDLE);
    assign cnt_inc   = cnt_reg + IDX_W'(1);
    assign i_plus    = (2*IDX_W)'(cnt_reg) + (2*IDX_W)'(1);
    // j = floor(r*(i+1)/N) never exceeds i, so the narrowed result cannot overflow
    assign swap_j    = IDX_W'(((2*IDX_W)'(lfsr_reg[IDX_W-1:0]) * i_plus) >> IDX_W);
    assign val_i     = perm_tab[cnt_reg];
    assign val_j     = perm_tab[swap_j];
    assign lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = INIT;
            INIT:    if (cnt_reg == CNT_MAX) state_next = SHUF;
            SHUF:    if (cnt_reg == IDX_W'(1)) state_next = STREAM;
            STREAM:  if (accept && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            lfsr_reg  <= LFSR_W'(1);
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg  <= '0;
                        lfsr_reg <= (seed == '0) ? LFSR_W'(1) : seed;
                    end
                end
                INIT: begin
                    if (cnt_reg != CNT_MAX) cnt_reg <= cnt_inc;
                end
                SHUF: begin
                    lfsr_reg <= lfsr_next;
                    cnt_reg  <= cnt_reg - IDX_W'(1);
                end
                STREAM: begin
                    // First STREAM cycle loads the output register; later loads follow handshakes
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= perm_tab[cnt_reg];
                        out_last  <= (cnt_reg == CNT_MAX);
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg  <= cnt_inc;
                            out_idx  <= perm_tab[cnt_inc];
                            out_last <= (cnt_inc == CNT_MAX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHUFFLE_INV_EN
    logic [IDX_W-1:0] inv_tab [N];
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_tab
            always_ff @(posedge clk) begin
                if (state_reg == INIT && cnt_reg == IDX_W'(gi))
                    perm_tab[gi] <= IDX_W'(gi);
                else if (state_reg == SHUF && cnt_reg == IDX_W'(gi))
                    perm_tab[gi] <= val_j;
                else if (state_reg == SHUF && swap_j == IDX_W'(gi))
                    perm_tab[gi] <= val_i;
            end
`ifdef SHUFFLE_INV_EN
            // Inverse entries follow the swapped values: value val_i moves to slot j, val_j to slot i
            always_ff @(posedge clk) begin
                if (state_reg == INIT && cnt_reg == IDX_W'(gi))
                    inv_tab[gi] <= IDX_W'(gi);
                else if (state_reg == SHUF && val_i == IDX_W'(gi))
                    inv_tab[gi] <= swap_j;
                else if (state_reg == SHUF && val_j == IDX_W'(gi))
                    inv_tab[gi] <= cnt_reg;
            end
`endif
        end
    endgenerate

`ifdef SHUFFLE_INV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inv_idx <= '0;
        else     inv_idx <= inv_tab[inv_addr];
    end
`endif

endmodule
